// File: rtl/alu_src_ctrl.sv
//==============================================================================
// alu_src_ctrl : multi-cycle datapath control FSM (Moore, state-decoded outputs)
// Revision 1.0
//==============================================================================
`default_nettype none

module alu_src_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       alu_src_a,
  output logic [3:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       i_or_d,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic [1:0] pc_source,
  output logic       opcode_err,
  output logic [3:0] state_out
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] SRCB_B     = 4'b0000;
  localparam logic [3:0] SRCB_FOUR  = 4'b0001;
  localparam logic [3:0] SRCB_SEXT  = 4'b0010;
  localparam logic [3:0] SRCB_SHIFT = 4'b0011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  state_t state;
  state_t next_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RST;
    end else begin
      state <= next_state;
    end
  end

  assign state_out = state;

  // Codes 13-15 fall into the default arm: outputs stay 0 and we recover via FETCH.
  always_comb begin
    next_state = S_FETCH;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALUOP_ADD;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    i_or_d     = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    pc_source  = PCSRC_ALU;
    opcode_err = 1'b0;

    case (state)
      S_RST: begin
        next_state = S_FETCH;
      end
      S_FETCH: begin
        mem_read   = 1'b1;
        ir_write   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        pc_write   = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_SHIFT;
        case (opcode)
          OP_RTYPE:     next_state = S_EXEC;
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JUMP;
          default: begin
            next_state = S_FETCH;
            opcode_err = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_SEXT;
        next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        i_or_d     = 1'b1;
        mem_read   = 1'b1;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWR: begin
        i_or_d     = 1'b1;
        mem_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_B;
        alu_op     = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_B;
        alu_op     = ALUOP_SUB;
        pc_source  = PCSRC_ALUOUT;
        pc_write   = zero;
        next_state = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_SEXT;
        next_state = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_JUMP: begin
        pc_source  = PCSRC_JUMP;
        pc_write   = 1'b1;
        next_state = S_FETCH;
      end
      default: begin
        next_state = S_FETCH;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_src_ctrl.sv
//==============================================================================
// tb_alu_src_ctrl : instruction-level randomized bench for alu_src_ctrl
// Revision 1.0
//==============================================================================
`default_nettype none

module tb_alu_src_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       alu_src_a;
  logic [3:0] alu_src_b;
  logic [1:0] alu_op;
  logic       pc_write, ir_write, mem_read, mem_write, reg_write;
  logic       i_or_d, mem_to_reg, reg_dst;
  logic [1:0] pc_source;
  logic       opcode_err;
  logic [3:0] state_out;

  int checks = 0;
  int errors = 0;
  bit run_mon = 1'b0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  alu_src_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .i_or_d(i_or_d),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .pc_source(pc_source),
    .opcode_err(opcode_err), .state_out(state_out)
  );

  always #5 clk = ~clk;

  wire [17:0] obs = {alu_src_a, alu_src_b, alu_op, pc_write, ir_write, mem_read,
                     mem_write, reg_write, i_or_d, mem_to_reg, reg_dst,
                     pc_source, opcode_err};

  function automatic bit supported(logic [5:0] op);
    return op inside {RT, LW, SW, BEQ, ADDI, JMP};
  endfunction

  // Instruction-level model: the sequence of states an opcode walks through from FETCH.
  function automatic int path_len(logic [5:0] op);
    case (op)
      LW:                 return 5;
      SW, RT, ADDI:       return 4;
      BEQ, JMP:           return 3;
      default:            return 2;
    endcase
  endfunction

  function automatic int path_state(logic [5:0] op, int k);
    int p[5];
    case (op)
      LW:      p = '{1, 2, 3, 4, 5};
      SW:      p = '{1, 2, 3, 6, 0};
      RT:      p = '{1, 2, 7, 8, 0};
      ADDI:    p = '{1, 2, 10, 11, 0};
      BEQ:     p = '{1, 2, 9, 0, 0};
      JMP:     p = '{1, 2, 12, 0, 0};
      default: p = '{1, 2, 0, 0, 0};
    endcase
    return p[k];
  endfunction

  function automatic logic [17:0] exp_out(int s, logic [5:0] op, logic z);
    logic       a, pcw, irw, mr, mw, rw, iod, m2r, rd, err;
    logic [3:0] b;
    logic [1:0] aop, psrc;
    {a, pcw, irw, mr, mw, rw, iod, m2r, rd, err} = '0;
    b = 4'd0; aop = 2'd0; psrc = 2'd0;
    case (s)
      1:      begin mr = 1; irw = 1; b = 4'd1; pcw = 1; end
      2:      begin b = 4'd3; err = !supported(op); end
      3, 10:  begin a = 1; b = 4'd2; end
      4:      begin iod = 1; mr = 1; end
      5:      begin rw = 1; m2r = 1; end
      6:      begin iod = 1; mw = 1; end
      7:      begin a = 1; aop = 2'd2; end
      8:      begin rw = 1; rd = 1; end
      9:      begin a = 1; aop = 2'd1; psrc = 2'd1; pcw = z; end
      11:     begin rw = 1; end
      12:     begin psrc = 2'd2; pcw = 1; end
      default: ;
    endcase
    return {a, b, aop, pcw, irw, mr, mw, rw, iod, m2r, rd, psrc, err};
  endfunction

  always @(negedge clk) begin
    if (run_mon) begin
      checks++;
      if (alu_src_b > 4'd3) begin
        errors++;
        $display("FAIL alu_src_b_range: got %b, required 0000..0011", alu_src_b);
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1; opcode = BAD; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    run_mon = 1'b1;
    checks++;
    if (state_out !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d, required 0", state_out); end
    checks++;
    if (obs !== 18'd0) begin errors++; $display("FAIL reset_outputs: got %h, required 0", obs); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (state_out !== 4'd1) begin errors++; $display("FAIL release_fetch: got %0d, required 1", state_out); end
    checks++;
    if (obs !== exp_out(1, opcode, zero)) begin
      errors++; $display("FAIL fetch_outputs: got %h, required %h", obs, exp_out(1, opcode, zero));
    end
    @(posedge clk); #1;
    checks++;
    if (state_out !== 4'd2) begin errors++; $display("FAIL release_decode: got %0d, required 2", state_out); end
    @(posedge clk); #1;
  endtask

  task automatic test_directed(input logic [5:0] op, input logic z, input string name);
    for (int k = 0; k < path_len(op); k++) begin
      int s;
      s = path_state(op, k);
      opcode = (s == 2 || s == 3) ? op : 6'($urandom);
      zero   = z;
      #1;
      checks++;
      if (state_out !== 4'(s)) begin
        errors++; $display("FAIL %s_state[%0d]: got %0d, required %0d", name, k, state_out, s);
      end
      checks++;
      if (obs !== exp_out(s, op, z)) begin
        errors++; $display("FAIL %s_outputs[%0d]: got %h, required %h", name, k, obs, exp_out(s, op, z));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_in_memwr();
    for (int k = 0; k < 4; k++) begin
      int s;
      s = path_state(SW, k);
      opcode = (s == 2 || s == 3) ? SW : 6'($urandom);
      zero   = 1'($urandom);
      #1;
      checks++;
      if (state_out !== 4'(s)) begin
        errors++; $display("FAIL sw_reset_path[%0d]: got %0d, required %0d", k, state_out, s);
      end
      if (k < 3) begin
        @(posedge clk); #1;
      end
    end
    checks++;
    if (mem_write !== 1'b1) begin errors++; $display("FAIL memwr_strobe: got %b, required 1", mem_write); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (state_out !== 4'd0) begin errors++; $display("FAIL midreset_state: got %0d, required 0", state_out); end
    checks++;
    if (obs !== 18'd0) begin errors++; $display("FAIL midreset_outputs: got %h, required 0", obs); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (state_out !== 4'd1) begin errors++; $display("FAIL midreset_fetch: got %0d, required 1", state_out); end
  endtask

  task automatic test_random();
    logic [5:0] pool[7];
    pool = '{RT, LW, SW, BEQ, ADDI, JMP, BAD};
    for (int n = 0; n < 300; n++) begin
      logic [5:0] op;
      op = (($urandom % 8) == 7) ? 6'($urandom) : pool[$urandom % 7];
      for (int k = 0; k < path_len(op); k++) begin
        int s;
        logic z;
        s = path_state(op, k);
        z = 1'($urandom);
        opcode = (s == 2 || s == 3) ? op : 6'($urandom);
        zero   = z;
        #1;
        checks++;
        if (state_out !== 4'(s)) begin
          errors++; $display("FAIL rand_state op=%b k=%0d: got %0d, required %0d", op, k, state_out, s);
        end
        checks++;
        if (obs !== exp_out(s, op, z)) begin
          errors++; $display("FAIL rand_outputs op=%b k=%0d: got %h, required %h", op, k, obs, exp_out(s, op, z));
        end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed(LW, 1'b0, "lw");
    test_directed(BEQ, 1'b1, "beq_taken");
    test_directed(BEQ, 1'b0, "beq_not_taken");
    test_directed(RT, 1'b0, "rtype");
    test_directed(BAD, 1'b1, "bad_opcode");
    test_directed(ADDI, 1'b0, "addi");
    test_directed(JMP, 1'b0, "jump");
    test_reset_in_memwr();
    test_random();
    run_mon = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_src_ctrl.md
ALU_SRC_CTRL -- requirements
Module: alu_src_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first: clk  in  1  system clock, rising edge.
REQ-002 reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
REQ-003 opcode  in  6  IR[31:26] of the current instruction.
REQ-004 zero  in  1  ALU zero flag, valid in BRANCH.
REQ-005 alu_src_a  out  1  ALU A mux select: 0=PC, 1=A register.
REQ-006 alu_src_b  out  4  ALU B mux select: 0000=B register, 0001=constant 4, 0010=SignExt, 0011=Shift2; other codes are never driven.
REQ-007 alu_op  out  2  00=add, 01=sub, 10=use funct field.
REQ-008 pc_write, ir_write, mem_read, mem_write, reg_write  out  1 each  write/read strobes.
REQ-009 i_or_d  out  1  0=PC address, 1=ALUOut address.
REQ-010 mem_to_reg, reg_dst  out  1 each  0=ALUOut / rt, 1=MDR / rd.
REQ-011 pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target.
REQ-012 opcode_err  out  1  one-cycle pulse on an unsupported opcode.
REQ-013 state_out  out  4  current state encoding, for debug.

Function
REQ-014 SHALL be a Moore FSM with outputs decoded from state only; pc_write is the only output that also depends on zero.
REQ-015 States and encodings: RST=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12; codes 13-15 are illegal.
REQ-016 Outputs not listed for a state SHALL be 0.
REQ-017 RST -> FETCH unconditionally; all outputs are 0 in RST.
REQ-018 FETCH: mem_read=1, ir_write=1, alu_src_a=0, alu_src_b=0001, alu_op=00, pc_source=00, pc_write=1; next state DECODE.
REQ-019 DECODE: alu_src_a=0, alu_src_b=0011, alu_op=00 (branch target into ALUOut).
REQ-020 DECODE transitions by opcode: 000000->EXEC; 100011 or 101011->MEMADR; 000100->BRANCH; 001000->ADDIEX; 000010->JUMP; any other -> FETCH with opcode_err=1 for that DECODE cycle.
REQ-021 MEMADR and ADDIEX: alu_src_a=1, alu_src_b=0010, alu_op=00.
REQ-022 MEMADR next state: MEMRD if opcode=100011, else MEMWR.
REQ-023 ADDIEX -> ADDIWB.
REQ-024 MEMRD: i_or_d=1, mem_read=1; next state MEMWB.
REQ-025 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; next state FETCH.
REQ-026 MEMWR: i_or_d=1, mem_write=1; next state FETCH.
REQ-027 EXEC: alu_src_a=1, alu_src_b=0000, alu_op=10; next state ALUWB.
REQ-028 ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; next state FETCH.
REQ-029 ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; next state FETCH.
REQ-030 BRANCH: alu_src_a=1, alu_src_b=0000, alu_op=01, pc_source=01, pc_write=zero; next state FETCH.
REQ-031 JUMP: pc_source=10, pc_write=1; next state FETCH.
REQ-032 Opcode SHALL be sampled only in DECODE and MEMADR; opcode changes in other states have no effect.
REQ-033 An illegal state code (13-15) SHALL go to FETCH on the next clock, with all outputs 0 while in it.
REQ-034 Instruction latency from FETCH entry: R-type 4, lw 5, sw 4, addi 4, beq 3, j 3 cycles; unsupported opcodes 2 cycles.
REQ-035 alu_src_b SHALL only take the values 0000, 0001, 0010 and 0011.

Reset
REQ-036 When reset=1 at a clock edge, the state SHALL become RST regardless of the current state, including mid-instruction.
REQ-037 Outputs SHALL be all 0 in the cycle after that edge; no write strobe may be asserted while in RST.
REQ-038 Release sequence: first FETCH occurs on the second edge after reset deasserts... specifically RST for one cycle, then FETCH.

Verification
REQ-039 Reset for 2 cycles, then release -> state_out sequence 0,1,2; all outputs 0 in state 0; FETCH shows alu_src_b=0001 and pc_write=1.
REQ-040 opcode=100011 (lw) -> states 1,2,3,4,5,1; alu_src_b 0001,0011,0010 in the first three states; reg_write=1 and mem_to_reg=1 only in state 5.
REQ-041 opcode=000100 (beq): with zero=1 -> pc_write=1 in BRANCH with pc_source=01 and alu_op=01; with zero=0 -> pc_write=0 in BRANCH; both cases return to FETCH.
REQ-042 opcode=000000 (R-type) -> EXEC shows alu_src_b=0000 and alu_op=10; ALUWB shows reg_dst=1; then FETCH.
REQ-043 opcode=111111 -> DECODE pulses opcode_err=1 for one cycle, then FETCH; no write strobe is asserted.
REQ-044 Assert reset in MEMWR (sw) -> next cycle state 0, mem_write=0; also a formal/assertion check that alu_src_b is never outside 0000-0011.
